// File: rtl/cbd_sampler.sv
// cbd_sampler: centered-binomial (eta=2) sampler filling a 256-entry mod-3329 polynomial
// from a stream of 32 random words, eight 4-bit nibbles per word.
module cbd_sampler (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] data_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        done_o,
  output logic [11:0] coeff_o [0:255]
);
  localparam logic [12:0] Q = 13'd3329;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state, state_n;
  logic [4:0] wcnt;
  logic [11:0] nc [8];
  logic we;
  for (genvar j = 0; j < 8; j++) begin : g_cbd
    logic [1:0] a, b;
    logic [12:0] d;
    assign a = {1'b0, data_i[4*j]} + {1'b0, data_i[4*j+1]};
    assign b = {1'b0, data_i[4*j+2]} + {1'b0, data_i[4*j+3]};
    assign d = {11'd0, a} - {11'd0, b};
    // a negative 13-bit difference wraps back into [0, Q-1] once Q is added
    assign nc[j] = 12'((a >= b) ? d : d + Q);
  end
  always_ff @(posedge clk_i) state <= !rst_ni ? IDLE : state_n;
  always_comb
    state_n = !start_i ? IDLE :
              state == IDLE ? LOAD :
              (state == LOAD && valid_i && wcnt == 5'd31) ? DONE : state;
  always_comb begin
    ready_o = state == LOAD;
    done_o  = state == DONE;
    we      = ready_o && start_i && valid_i;
  end
  always_ff @(posedge clk_i)
    if (!rst_ni) wcnt <= '0;
    else wcnt <= (state == LOAD && start_i) ? wcnt + 5'(we) : 5'd0;
  always_ff @(posedge clk_i)
    if (!rst_ni) for (int i = 0; i < 256; i++) coeff_o[i] <= '0;
    else if (we) for (int j = 0; j < 8; j++) coeff_o[{wcnt, 3'(j)}] <= nc[j];
endmodule

// File: tb/tb_cbd_sampler.sv
// tb_cbd_sampler: scoreboard bench; each accepted word queues its 8 expected coefficients,
// checked the cycle after the transfer, plus whole-array checks against a reference image.
module tb_cbd_sampler;
  logic clk_i = 0, rst_ni = 0, start_i = 0, valid_i = 0;
  logic [31:0] data_i = '0;
  logic ready_o, done_o;
  logic [11:0] coeff_o [0:255];
  typedef struct packed {logic [4:0] w; logic [95:0] c;} ent_t;
  ent_t sb[$];
  logic [11:0] model [256];
  int total = 0, bad = 0, tw = 0;

  cbd_sampler dut (.clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .data_i(data_i),
                   .valid_i(valid_i), .ready_o(ready_o), .done_o(done_o), .coeff_o(coeff_o));

  always #5 clk_i = ~clk_i;

  function automatic logic [11:0] cbd(input logic [3:0] n);
    int a, b;
    a = int'(n[0]) + int'(n[1]);
    b = int'(n[2]) + int'(n[3]);
    return (a >= b) ? 12'(a - b) : 12'(3329 + a - b);
  endfunction

  function automatic logic [31:0] word_of(input int mode, input int k);
    return mode == 1 ? (k == 0 ? 32'h4C13C3C3 : 32'h55555555) :
           mode == 2 ? (k % 2 == 1 ? 32'h11111111 : 32'h0) :
           mode == 3 ? 32'h33333333 : 32'h0;
  endfunction

  task automatic drain();
    ent_t e;
    logic [95:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      for (int j = 0; j < 8; j++) act[12*j+:12] = coeff_o[8*int'(e.w)+j];
      total++;
      if (act !== e.c) begin
        bad++;
        $display("FAIL word%0d: got %h want %h", e.w, act, e.c);
      end
    end
  endtask

  task automatic step(input logic v, input logic [31:0] d);
    ent_t e;
    @(negedge clk_i);
    drain();
    valid_i = v;
    data_i = d;
    if (v && ready_o && start_i) begin
      e.w = 5'(tw);
      for (int j = 0; j < 8; j++) begin
        e.c[12*j+:12] = cbd(d[4*j+:4]);
        model[8*tw+j] = e.c[12*j+:12];
      end
      sb.push_back(e);
      tw++;
    end
  endtask

  task automatic check_all(input string name);
    int n = 0;
    for (int i = 0; i < 256; i++) if (coeff_o[i] !== model[i]) n++;
    total++;
    if (n != 0) begin
      bad++;
      $display("FAIL %s: %0d coefficients differ from reference, required 0", name, n);
    end
  endtask

  task automatic run(input string name, input int mode, input bit toggle, input int want);
    int cyc = 0;
    bit ph = 1;
    tw = 0;
    @(negedge clk_i);
    start_i = 1;
    valid_i = 0;
    while (1) begin
      step(toggle ? ph : 1'b1, word_of(mode, tw));
      ph = !ph;
      cyc++;
      if (done_o || cyc >= 200) break;
    end
    drain();
    total++;
    if (cyc != want || done_o !== 1'b1) begin
      bad++;
      $display("FAIL %s_done: cycles=%0d done=%b, required cycles=%0d done=1", name, cyc, done_o, want);
    end
    total++;
    if (ready_o !== 1'b0) begin
      bad++;
      $display("FAIL %s_ready: got %b want 0", name, ready_o);
    end
    check_all(name);
  endtask

  task automatic test_reset();
    rst_ni = 0;
    start_i = 1;
    for (int i = 0; i < 256; i++) model[i] = '0;
    repeat (2) @(negedge clk_i);
    total++;
    if (done_o !== 1'b0 || ready_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: done=%b ready=%b, required 0 0", done_o, ready_o);
    end
    check_all("reset_coeff");
    rst_ni = 1;
    @(negedge clk_i);
    total++;
    if (ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_load: ready=%b want 1", ready_o);
    end
    start_i = 0;
    @(negedge clk_i);
    total++;
    if (ready_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: ready=%b want 0", ready_o);
    end
  endtask

  task automatic test_zero();
    run("zero", 0, 0, 33);
    start_i = 0;
  endtask

  task automatic test_nibble();
    logic [11:0] exp8 [8] = '{12'd2, 12'd3327, 12'd2, 12'd3327, 12'd2, 12'd1, 12'd3327, 12'd3328};
    int n = 0;
    run("nibble", 1, 0, 33);
    for (int j = 0; j < 8; j++) if (coeff_o[j] !== exp8[j]) n++;
    total++;
    if (n != 0) begin
      bad++;
      $display("FAIL nibble_word0: %0d of coeff[0..7] wrong, got %0d %0d %0d %0d %0d %0d %0d %0d",
               n, coeff_o[0], coeff_o[1], coeff_o[2], coeff_o[3], coeff_o[4], coeff_o[5], coeff_o[6], coeff_o[7]);
    end
    start_i = 0;
  endtask

  task automatic test_backpressure();
    run("backpressure", 2, 1, 64);
    start_i = 0;
  endtask

  task automatic test_abort();
    int cyc = 0;
    int n = 0;
    tw = 0;
    @(negedge clk_i);
    start_i = 1;
    valid_i = 0;
    while (tw < 10 && cyc < 50) begin
      step(1'b1, 32'hCCCCCCCC);
      cyc++;
    end
    @(negedge clk_i);
    drain();
    start_i = 0;
    valid_i = 1;
    data_i = 32'hCCCCCCCC;
    @(negedge clk_i);
    valid_i = 0;
    total++;
    if (ready_o !== 1'b0 || done_o !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle: ready=%b done=%b, required 0 0", ready_o, done_o);
    end
    check_all("abort_partial");
    run("restart", 3, 0, 33);
    for (int i = 0; i < 256; i++) if (coeff_o[i] !== 12'd2) n++;
    total++;
    if (n != 0) begin
      bad++;
      $display("FAIL restart_all2: %0d coefficients not 2, required 0", n);
    end
  endtask

  task automatic test_done_hold();
    for (int k = 0; k < 20; k++) begin
      step(1'b1, $urandom);
      total++;
      if (done_o !== 1'b1 || ready_o !== 1'b0) begin
        bad++;
        $display("FAIL done_hold_c%0d: done=%b ready=%b, required 1 0", k, done_o, ready_o);
      end
    end
    check_all("done_hold");
    start_i = 0;
    valid_i = 0;
    @(negedge clk_i);
    total++;
    if (done_o !== 1'b0) begin
      bad++;
      $display("FAIL done_release: done=%b want 0", done_o);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_nibble();
    test_backpressure();
    test_abort();
    test_done_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
